// File: rtl/commutation_request_gen_pkg.sv
// Shared definitions between the commutation request generator and the commutation FSM:
// phase-select load codes and the local control-state encoding.
package commutation_request_gen_pkg;

  localparam int LOAD_W = 2;

  typedef enum logic [LOAD_W-1:0] {
    NUL = 2'b00,
    LAA = 2'b01,
    LBB = 2'b10,
    LCC = 2'b11
  } load_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_RUN   = 2'b01,
    ST_FAULT = 2'b10
  } state_e;

endpackage

// File: rtl/commutation_request_gen_current_sign_filter.sv
// Source-current sign detector: hysteresis band plus debounce on valid samples,
// and a combinational overcurrent compare on the same sample.
module commutation_request_gen_current_sign_filter
  import commutation_request_gen_pkg::*;
#(
  parameter int I_W      = 12,
  parameter int HYST     = 16,
  parameter int DEBOUNCE = 4,
  parameter int I_TRIP   = 1800
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic [I_W-1:0] i_meas_i,
  input  logic           i_valid_i,
  output logic           sign_o,
  output logic           over_o
);

  localparam int DB_W = (DEBOUNCE < 2) ? 1 : $clog2(DEBOUNCE);
  localparam logic [DB_W-1:0]       DB_LAST = DB_W'(DEBOUNCE - 1);
  localparam logic signed [I_W:0]   HYST_P  = (I_W + 1)'(HYST);
  localparam logic signed [I_W:0]   HYST_N  = -HYST_P;
  localparam logic [I_W:0]          TRIP    = (I_W + 1)'(I_TRIP);

  logic signed [I_W:0] i_ext;
  logic [I_W:0]        i_mag;
  logic                is_pos;
  logic                is_neg;
  logic                sign_q, sign_d;
  logic [DB_W-1:0]     db_cnt_q, db_cnt_d;

  // One extra bit so the magnitude of the most negative sample does not overflow.
  assign i_ext  = {i_meas_i[I_W-1], i_meas_i};
  assign i_mag  = i_ext[I_W] ? $unsigned(-i_ext) : $unsigned(i_ext);
  assign is_pos = i_ext > HYST_P;
  assign is_neg = i_ext < HYST_N;
  assign over_o = i_valid_i && (i_mag > TRIP);
  assign sign_o = sign_q;

  // The counter only advances on samples that argue for the opposite sign.
  always_comb begin
    sign_d   = sign_q;
    db_cnt_d = db_cnt_q;
    if (i_valid_i) begin
      if ((is_pos && !sign_q) || (is_neg && sign_q)) begin
        if (db_cnt_q == DB_LAST) begin
          sign_d   = !sign_q;
          db_cnt_d = '0;
        end else begin
          db_cnt_d = db_cnt_q + DB_W'(1);
        end
      end else begin
        db_cnt_d = '0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sign_q   <= 1'b0;
      db_cnt_q <= '0;
    end else begin
      sign_q   <= sign_d;
      db_cnt_q <= db_cnt_d;
    end
  end

endmodule

// File: rtl/commutation_request_gen.sv
// Generates the per-period A->B->C DesiredLoad sequence from shadowed duty commands,
// owns the sticky Short fault and forwards the debounced current sign.
module commutation_request_gen
  import commutation_request_gen_pkg::*;
#(
  parameter int CNT_W     = 12,
  parameter int PERIOD    = 1000,
  parameter int MIN_DWELL = 8,
  parameter int I_W       = 12,
  parameter int HYST      = 16,
  parameter int DEBOUNCE  = 4,
  parameter int I_TRIP    = 1800
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [CNT_W-1:0]  duty_a,
  input  logic [CNT_W-1:0]  duty_b,
  input  logic              duty_valid,
  input  logic [I_W-1:0]    i_meas,
  input  logic              i_valid,
  input  logic              fault_in,
  input  logic              fault_clr,
  output logic [LOAD_W-1:0] DesiredLoad,
  output logic              CurrentSign,
  output logic              Short,
  output logic              period_start
);

  localparam logic [CNT_W:0]   PER      = (CNT_W + 1)'(PERIOD);
  localparam logic [CNT_W:0]   MDW      = (CNT_W + 1)'(MIN_DWELL);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(PERIOD - 1);

  state_e           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] shadow_a_q, shadow_b_q;
  logic [CNT_W:0]   end_a_q, end_b_q;
  logic [1:0]       fault_sync_q;
  load_e            load_q;
  logic             period_start_q;
  logic             short_q;

  logic             over_cur;
  logic             fault_set;
  logic             run_go;
  logic             cnt_wrap;
  logic [CNT_W:0]   seg_a, seg_b, seg_c;
  load_e            seg_load;

  assign fault_set = fault_sync_q[1] | over_cur;
  assign cnt_wrap  = (cnt_q == CNT_LAST);
  assign run_go    = (state_q == ST_RUN) && start && !fault_set;

  // Segment lengths from the shadow duties; every nonzero segment ends up >= MIN_DWELL.
  always_comb begin
    seg_a = {1'b0, shadow_a_q};
    if (seg_a > PER) seg_a = PER;
    seg_b = {1'b0, shadow_b_q};
    if (seg_b > PER - seg_a) seg_b = PER - seg_a;
    if (seg_a != '0 && seg_a < MDW) begin
      seg_b = seg_b + seg_a;
      seg_a = '0;
    end
    if (seg_b != '0 && seg_b < MDW) seg_b = '0;
    seg_c = PER - seg_a - seg_b;
    if (seg_c != '0 && seg_c < MDW) begin
      if (seg_b != '0) seg_b = seg_b + seg_c;
      else             seg_a = seg_a + seg_c;
    end
  end

  always_comb begin
    if ({1'b0, cnt_q} < end_a_q)      seg_load = LAA;
    else if ({1'b0, cnt_q} < end_b_q) seg_load = LBB;
    else                              seg_load = LCC;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shadow_a_q   <= '0;
      shadow_b_q   <= '0;
      fault_sync_q <= '0;
    end else begin
      fault_sync_q <= {fault_sync_q[0], fault_in};
      if (duty_valid) begin
        shadow_a_q <= duty_a;
        shadow_b_q <= duty_b;
      end
    end
  end

  // Active bounds reload whenever the next cnt is 0, so a same-cycle shadow write waits a period.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      end_a_q <= '0;
      end_b_q <= '0;
    end else if (!run_go || cnt_wrap) begin
      end_a_q <= seg_a;
      end_b_q <= seg_a + seg_b;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= ST_IDLE;
      cnt_q          <= '0;
      load_q         <= NUL;
      period_start_q <= 1'b0;
      short_q        <= 1'b0;
    end else begin
      load_q         <= NUL;
      period_start_q <= 1'b0;
      cnt_q          <= '0;
      if (fault_set) begin
        state_q <= ST_FAULT;
        short_q <= 1'b1;
      end else begin
        case (state_q)
          ST_IDLE: begin
            if (start) state_q <= ST_RUN;
          end
          ST_RUN: begin
            if (!start) begin
              state_q <= ST_IDLE;
            end else begin
              cnt_q          <= cnt_wrap ? '0 : cnt_q + CNT_W'(1);
              load_q         <= seg_load;
              period_start_q <= (cnt_q == '0);
            end
          end
          ST_FAULT: begin
            if (fault_clr) begin
              state_q <= ST_IDLE;
              short_q <= 1'b0;
            end
          end
          default: begin
            state_q <= ST_IDLE;
            short_q <= 1'b0;
          end
        endcase
      end
    end
  end

  commutation_request_gen_current_sign_filter #(
    .I_W      (I_W),
    .HYST     (HYST),
    .DEBOUNCE (DEBOUNCE),
    .I_TRIP   (I_TRIP)
  ) u_sign_filter (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_meas_i  (i_meas),
    .i_valid_i (i_valid),
    .sign_o    (CurrentSign),
    .over_o    (over_cur)
  );

  assign DesiredLoad  = load_q;
  assign Short        = short_q;
  assign period_start = period_start_q;

endmodule
